// File: rtl/gas_alarm_ctrl.sv
// Multi-channel gas-sensor alarm front end: per-channel 2-FF synchroniser, persistence
// debounce FSM, and live / sticky / rising-edge alarm flags with acknowledge.
module gas_alarm_ctrl #(
  parameter int CH         = 4,
  parameter int DEB_CYC    = 50000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] DO,
  input  logic [CH-1:0] en,
  input  logic          ack,
  output logic [CH-1:0] gas_signal,
  output logic [CH-1:0] gas_latch,
  output logic [CH-1:0] gas_rise,
  output logic          gas_any
);

  localparam int            CW        = $clog2(DEB_CYC + 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYC);
  localparam logic          INACT_LVL = (ACTIVE_LOW != 0);
  localparam logic          ACT_LVL   = ~INACT_LVL;

  typedef enum logic [1:0] {
    IDLE,
    ASSERT_WAIT,
    ACTIVE,
    RELEASE_WAIT
  } state_t;

  logic [CH-1:0] sync1_q, sync2_q, s_act;

  // A disabled channel's synchroniser is held at the inactive level, so re-enabling
  // pays the full synchroniser plus debounce latency again.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= {CH{INACT_LVL}};
      sync2_q <= {CH{INACT_LVL}};
    end else begin
      sync1_q <= (DO & en)      | ({CH{INACT_LVL}} & ~en);
      sync2_q <= (sync1_q & en) | ({CH{INACT_LVL}} & ~en);
    end
  end

  assign s_act   = ~(sync2_q ^ {CH{ACT_LVL}}) & en;
  assign gas_any = |gas_latch;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          sig_q, sig_d;
    logic          latch_q, latch_d;
    logic          rise_q, rise_d;

    assign cnt_inc = cnt_q + 1'b1;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!en[g]) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        unique case (state_q)
          IDLE: if (s_act[g]) begin
            if (DEB_CYC == 1) state_d = ACTIVE;
            else begin
              state_d = ASSERT_WAIT;
              cnt_d   = CW'(1);
            end
          end
          ASSERT_WAIT: begin
            if (!s_act[g]) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else if (cnt_inc == DEB_LAST) begin
              state_d = ACTIVE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
          ACTIVE: if (!s_act[g]) begin
            if (DEB_CYC == 1) state_d = IDLE;
            else begin
              state_d = RELEASE_WAIT;
              cnt_d   = CW'(1);
            end
          end
          RELEASE_WAIT: begin
            if (s_act[g]) begin
              state_d = ACTIVE;
              cnt_d   = '0;
            end else if (cnt_inc == DEB_LAST) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
          default: begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end

    // A rise always implies sig_q is 0, so letting it override the ack clear gives set-wins.
    assign sig_d   = (state_d == ACTIVE) || (state_d == RELEASE_WAIT);
    assign rise_d  = en[g] & sig_d & ~sig_q;
    assign latch_d = en[g] & (rise_d | (latch_q & ~(ack & ~sig_q)));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        sig_q   <= 1'b0;
        latch_q <= 1'b0;
        rise_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        sig_q   <= sig_d;
        latch_q <= latch_d;
        rise_q  <= rise_d;
      end
    end

    assign gas_signal[g] = sig_q;
    assign gas_latch[g]  = latch_q;
    assign gas_rise[g]   = rise_q;
  end

endmodule

// File: tb/tb_gas_alarm_ctrl.sv
// Bench for gas_alarm_ctrl: directed latency/ack/enable/reset checks plus randomized
// traffic, both polarities compared every cycle against a run-length behavioural model.
module tb_gas_alarm_ctrl;

  localparam int CH  = 4;
  localparam int DEB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [CH-1:0] do_v = '1;
  logic [CH-1:0] en_v = '1;
  logic          ack_v = 1'b0;
  logic [CH-1:0] do_b;

  logic [CH-1:0] sig_a, latch_a, rise_a, sig_b, latch_b, rise_b;
  logic          any_a, any_b;

  int n_checks = 0;
  int n_fail   = 0;

  assign do_b = ~do_v;

  always #5 clk = ~clk;

  gas_alarm_ctrl #(.CH(CH), .DEB_CYC(DEB), .ACTIVE_LOW(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .DO(do_v), .en(en_v), .ack(ack_v),
    .gas_signal(sig_a), .gas_latch(latch_a), .gas_rise(rise_a), .gas_any(any_a)
  );

  gas_alarm_ctrl #(.CH(CH), .DEB_CYC(DEB), .ACTIVE_LOW(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .DO(do_b), .en(en_v), .ack(ack_v),
    .gas_signal(sig_b), .gas_latch(latch_b), .gas_rise(rise_b), .gas_any(any_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model in "gas present" terms: the live flag toggles once the synchronised level has
  // disagreed with it for DEB consecutive cycles.
  logic [CH-1:0] m_s1 = '0, m_s2 = '0, m_sig = '0, m_latch = '0, m_rise = '0;
  int            m_run [CH];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 <= '0; m_s2 <= '0; m_sig <= '0; m_latch <= '0; m_rise <= '0;
      for (int i = 0; i < CH; i++) m_run[i] <= 0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (!en_v[i]) begin
          m_s1[i] <= 1'b0; m_s2[i] <= 1'b0; m_sig[i] <= 1'b0;
          m_latch[i] <= 1'b0; m_rise[i] <= 1'b0; m_run[i] <= 0;
        end else begin
          automatic int run = (m_s2[i] != m_sig[i]) ? m_run[i] + 1 : 0;
          automatic bit sig = m_sig[i];
          automatic bit rise = 1'b0;
          if (run == DEB) begin
            sig  = ~sig;
            run  = 0;
            rise = sig;
          end
          m_latch[i] <= rise | (m_latch[i] & !(ack_v & !m_sig[i]));
          m_rise[i]  <= rise;
          m_sig[i]   <= sig;
          m_run[i]   <= run;
          m_s2[i]    <= m_s1[i];
          m_s1[i]    <= ~do_v[i];
        end
      end
    end
  end

  always @(negedge clk) begin
    check("a_signal", 32'(sig_a),   32'(m_sig));
    check("a_latch",  32'(latch_a), 32'(m_latch));
    check("a_rise",   32'(rise_a),  32'(m_rise));
    check("a_any",    32'(any_a),   32'(|m_latch));
    check("b_signal", 32'(sig_b),   32'(m_sig));
    check("b_latch",  32'(latch_b), 32'(m_latch));
    check("b_rise",   32'(rise_b),  32'(m_rise));
    check("b_any",    32'(any_b),   32'(|m_latch));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ack_pulse();
    ack_v = 1'b1;
    tick();
    ack_v = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) tick();
    check("rst_signal", 32'(sig_a), 32'h0);
    check("rst_latch",  32'(latch_a), 32'h0);
    check("rst_any",    32'(any_a), 32'h0);
    rst_n = 1'b1;
    repeat (4) tick();

    // ch0 asserts: high after edge DEB+2, rise for one cycle only
    do_v[0] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check($sformatf("assert_sig_e%0d", k),   32'(sig_a[0]),   32'(k >= 6));
      check($sformatf("assert_rise_e%0d", k),  32'(rise_a[0]),  32'(k == 6));
      check($sformatf("assert_latch_e%0d", k), 32'(latch_a[0]), 32'(k >= 6));
    end
    check("assert_any", 32'(any_a), 32'h1);
    check("assert_others", 32'(sig_a[3:1]), 32'h0);

    // ch1 glitches of DEB-1 cycles with 1-cycle gaps never assert
    repeat (5) begin
      do_v[1] = 1'b0;
      repeat (DEB - 1) tick();
      do_v[1] = 1'b1;
      tick();
    end
    repeat (6) tick();
    check("glitch_sig", 32'(sig_a[1]), 32'h0);
    check("glitch_latch", 32'(latch_a[1]), 32'h0);

    // ch0 release, latch sticky until ack
    do_v[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("release_sig_e%0d", k), 32'(sig_a[0]), 32'(k < 6));
      check($sformatf("release_latch_e%0d", k), 32'(latch_a[0]), 32'h1);
    end
    ack_pulse();
    check("ack_clear_latch", 32'(latch_a[0]), 32'h0);
    check("ack_clear_any", 32'(any_a), 32'h0);

    // ack while ch2 alarming, and on the very edge ch3 rises
    do_v[2] = 1'b0;
    repeat (8) tick();
    check("ch2_sig", 32'(sig_a[2]), 32'h1);
    do_v[3] = 1'b0;
    repeat (5) tick();
    ack_pulse();
    check("ch3_rise_with_ack", 32'(rise_a[3]), 32'h1);
    check("ch3_latch_with_ack", 32'(latch_a[3]), 32'h1);
    check("ch2_latch_kept", 32'(latch_a[2]), 32'h1);
    do_v[3:2] = 2'b11;
    repeat (8) tick();
    ack_pulse();
    check("clean_any", 32'(any_a), 32'h0);

    // enable drop while alarming, then full-latency re-assert
    do_v[0] = 1'b0;
    repeat (8) tick();
    check("en_pre_sig", 32'(sig_a[0]), 32'h1);
    en_v[0] = 1'b0;
    tick();
    check("en_off_sig", 32'(sig_a[0]), 32'h0);
    check("en_off_latch", 32'(latch_a[0]), 32'h0);
    check("en_off_rise", 32'(rise_a[0]), 32'h0);
    repeat (3) tick();
    en_v[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("reen_sig_e%0d", k), 32'(sig_a[0]), 32'(k >= 6));
      check($sformatf("reen_rise_e%0d", k), 32'(rise_a[0]), 32'(k == 6));
    end

    // async reset with ch0 active and ch1 mid-debounce
    do_v[1] = 1'b0;
    repeat (3) tick();
    #1 rst_n = 1'b0;
    #1;
    check("midrst_sig_a", 32'(sig_a), 32'h0);
    check("midrst_latch_a", 32'(latch_a), 32'h0);
    check("midrst_any_a", 32'(any_a), 32'h0);
    check("midrst_sig_b", 32'(sig_b), 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check($sformatf("postrst_sig_e%0d", k), 32'(sig_a[1:0]), (k >= 6) ? 32'h3 : 32'h0);
      check($sformatf("postrst_sig_b_e%0d", k), 32'(sig_b[1:0]), (k >= 6) ? 32'h3 : 32'h0);
    end
    do_v = '1;
    repeat (8) tick();
    ack_pulse();

    // randomized traffic, checked every cycle by the compare process
    repeat (3000) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 5) == 0) do_v[i] = ~do_v[i];
        if ($urandom_range(0, 149) == 0) en_v[i] = ~en_v[i];
      end
      ack_v = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      tick();
    end
    ack_v = 1'b0;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
